// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// byte-lane masks and the request decode helpers.
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } lsu_state_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Unsigned sizes only exist for loads, hence the store check on size[2].
   function automatic logic size_legal(input logic [2:0] size,
                                       input logic [1:0] lane,
                                       input logic       we);
      logic ok;
      case (size)
         LSU_B, LSU_BU: ok = 1'b1;
         LSU_H, LSU_HU: ok = ~lane[0];
         LSU_W:         ok = (lane == 2'b00);
         default:       ok = 1'b0;
      endcase
      return ok & ~(we & size[2]);
   endfunction

   function automatic logic [3:0] byte_mask(input logic [2:0] size,
                                            input logic [1:0] lane);
      logic [3:0] m;
      case (size)
         LSU_B, LSU_BU: m = MASK_B << lane;
         LSU_H, LSU_HU: m = MASK_H << lane;
         LSU_W:         m = MASK_W;
         default:       m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0]  size,
                                              input logic [31:0] wd);
      logic [31:0] d;
      case (size)
         LSU_B:   d = {4{wd[7:0]}};
         LSU_H:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] mem_rd,
   input  logic [1:0]  lane,
   input  logic [2:0]  size,
   output logic [31:0] data
);

   function automatic logic [31:0] sext8(input logic signed [7:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] v);
      logic signed [31:0] w;
      w = v;
      return w;
   endfunction

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_rd[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (size)
         LSU_B:   data = sext8(byte_sel);
         LSU_BU:  data = {24'd0, byte_sel};
         LSU_H:   data = sext16(half_sel);
         LSU_HU:  data = {16'd0, half_sel};
         LSU_W:   data = mem_rd;
         default: data = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store unit: decodes a MEM-stage access, runs the REQ/GNT
// handshake with main memory, stalls the core and returns extended load data.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_IN,
   input  logic        WE_IN,
   input  logic [2:0]  SIZE,
   input  logic [31:0] A,
   input  logic [31:0] WD_IN,
   output logic [31:0] RD_OUT,
   output logic        STALL,
   output logic        ERR_OUT,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [3:0]  MEM_BYTES,
   output logic [31:0] MEM_AD,
   output logic [31:0] MEM_WD,
   input  logic [31:0] MEM_RD,
   input  logic        MEM_GNT,
   input  logic        MEM_ERR
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic              legal;
   logic [3:0]        bytes_dec;
   logic [31:0]       wd_dec;
   logic [2:0]        size_q;
   logic [1:0]        lane_q;
   logic              we_q;
   logic [3:0]        bytes_q;
   logic [31:0]       ad_q;
   logic [31:0]       wd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rd_q;
   logic              err_q;
   logic [31:0]       load_data;
   logic              timeout;

   always_comb begin
      legal     = size_legal(SIZE, A[1:0], WE_IN);
      bytes_dec = byte_mask(SIZE, A[1:0]);
      wd_dec    = store_data(SIZE, WD_IN);
      timeout   = ~MEM_GNT & (cnt_q == CNT_LAST);
   end

   lsu_load_align u_align (
      .mem_rd (MEM_RD),
      .lane   (lane_q),
      .size   (size_q),
      .data   (load_data)
   );

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // GNT has priority over the timeout on the final ISSUE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (REQ_IN) state_d = legal ? ST_ISSUE : ST_DONE;
         ST_ISSUE: begin
            if (MEM_GNT)      state_d = ST_WAIT;
            else if (timeout) state_d = ST_DONE;
         end
         ST_WAIT:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         size_q  <= 3'd0;
         lane_q  <= 2'd0;
         we_q    <= 1'b0;
         bytes_q <= 4'd0;
         ad_q    <= 32'd0;
         wd_q    <= 32'd0;
         cnt_q   <= '0;
         rd_q    <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (REQ_IN && legal) begin
                  size_q  <= SIZE;
                  lane_q  <= A[1:0];
                  we_q    <= WE_IN;
                  bytes_q <= bytes_dec;
                  ad_q    <= {A[31:2], 2'b00};
                  wd_q    <= wd_dec;
                  cnt_q   <= '0;
               end else if (REQ_IN) begin
                  err_q <= 1'b1;
                  rd_q  <= 32'd0;
               end
            end
            ST_ISSUE: begin
               if (timeout) begin
                  err_q <= 1'b1;
                  rd_q  <= 32'd0;
               end else if (!MEM_GNT) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               err_q <= MEM_ERR;
               rd_q  <= (MEM_ERR || we_q) ? 32'd0 : load_data;
            end
            ST_DONE: begin
               err_q <= 1'b0;
               rd_q  <= 32'd0;
            end
            default: begin
               err_q <= 1'b0;
               rd_q  <= 32'd0;
            end
         endcase
      end
   end

   assign MEM_REQ   = (state_q == ST_ISSUE);
   assign MEM_WE    = we_q;
   assign MEM_BYTES = bytes_q;
   assign MEM_AD    = ad_q;
   assign MEM_WD    = wd_q;
   assign RD_OUT    = rd_q;
   assign ERR_OUT   = err_q;
   assign STALL     = REQ_IN & (state_q != ST_DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small registered-read memory model.
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ_IN;
   logic        WE_IN;
   logic [2:0]  SIZE;
   logic [31:0] A;
   logic [31:0] WD_IN;
   logic [31:0] RD_OUT;
   logic        STALL;
   logic        ERR_OUT;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [3:0]  MEM_BYTES;
   logic [31:0] MEM_AD;
   logic [31:0] MEM_WD;
   logic [31:0] MEM_RD;
   logic        MEM_GNT;
   logic        MEM_ERR;

   logic        gnt_en;
   logic        err_inj;
   logic [31:0] mem [64];

   int checks = 0;
   int fails  = 0;

   always #5 CLK = ~CLK;

   load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST), .REQ_IN(REQ_IN), .WE_IN(WE_IN), .SIZE(SIZE),
      .A(A), .WD_IN(WD_IN), .RD_OUT(RD_OUT), .STALL(STALL), .ERR_OUT(ERR_OUT),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BYTES(MEM_BYTES), .MEM_AD(MEM_AD),
      .MEM_WD(MEM_WD), .MEM_RD(MEM_RD), .MEM_GNT(MEM_GNT), .MEM_ERR(MEM_ERR)
   );

   assign MEM_GNT = MEM_REQ & gnt_en;

   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
         MEM_RD  <= 32'd0;
         MEM_ERR <= 1'b0;
      end else if (MEM_REQ && MEM_GNT) begin
         MEM_RD  <= mem[MEM_AD[7:2]];
         MEM_ERR <= err_inj;
         if (MEM_WE)
            for (int i = 0; i < 4; i++)
               if (MEM_BYTES[i]) mem[MEM_AD[7:2]][8*i +: 8] <= MEM_WD[8*i +: 8];
      end else begin
         MEM_ERR <= 1'b0;
      end
   end

   // Drives one access and observes it until DONE (STALL drops with REQ_IN high).
   task automatic do_access(input logic we, input logic [2:0] size,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err,
                            output int stalls, output int reqs,
                            output logic [3:0] bytes, output logic [31:0] mwd,
                            output logic [31:0] mad);
      bit done;
      done = 0; stalls = 0; reqs = 0; bytes = 4'd0; mwd = 32'd0; mad = 32'd0;
      rd = 32'd0; err = 1'b0;
      @(negedge CLK);
      REQ_IN = 1'b1; WE_IN = we; SIZE = size; A = a; WD_IN = wd;
      for (int c = 0; c < 64 && !done; c++) begin
         #1;
         if (MEM_REQ) begin
            reqs++; bytes = MEM_BYTES; mwd = MEM_WD; mad = MEM_AD;
         end
         if (!STALL) begin
            rd = RD_OUT; err = ERR_OUT; done = 1;
         end else begin
            stalls++;
            @(negedge CLK);
         end
      end
      if (!done) begin
         checks++; fails++;
         $display("FAIL access_timeout: STALL never dropped, required DONE within 64 cycles");
      end
      REQ_IN = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      @(negedge CLK); #1;
      checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", MEM_REQ); end
      checks++; if (STALL !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", STALL); end
      checks++; if (ERR_OUT !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", ERR_OUT); end
      checks++; if (RD_OUT !== 32'd0) begin fails++; $display("FAIL reset_rd: got %h want 0", RD_OUT); end
      checks++; if ({MEM_WE, MEM_BYTES, MEM_AD, MEM_WD} !== 69'd0) begin
         fails++; $display("FAIL reset_mem_bus: got we=%b bytes=%b ad=%h wd=%h want all 0", MEM_WE, MEM_BYTES, MEM_AD, MEM_WD);
      end
      RST = 1'b0;
   endtask

   task automatic test_sw();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, st, rq, by, mwd, mad);
      checks++; if (by !== 4'b1111) begin fails++; $display("FAIL sw_bytes: got %b want 1111", by); end
      checks++; if (mwd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wd: got %h want deadbeef", mwd); end
      checks++; if (mad !== 32'h10) begin fails++; $display("FAIL sw_ad: got %h want 00000010", mad); end
      checks++; if (st !== 3) begin fails++; $display("FAIL sw_stall: got %0d want 3", st); end
      checks++; if (err !== 1'b0 || rd !== 32'd0) begin fails++; $display("FAIL sw_done: got err=%b rd=%h want 0/0", err, rd); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
   endtask

   task automatic test_byte();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      do_access(1'b1, 3'b000, 32'h13, 32'h000000AB, rd, err, st, rq, by, mwd, mad);
      checks++; if (by !== 4'b1000) begin fails++; $display("FAIL sb_bytes: got %b want 1000", by); end
      checks++; if (mwd !== 32'hABABABAB) begin fails++; $display("FAIL sb_wd: got %h want abababab", mwd); end
      checks++; if (mem[4] !== 32'hABADBEEF) begin fails++; $display("FAIL sb_mem: got %h want abadbeef", mem[4]); end
      do_access(1'b0, 3'b000, 32'h13, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (rd !== 32'hFFFFFFAB) begin fails++; $display("FAIL lb_rd: got %h want ffffffab", rd); end
      checks++; if (by !== 4'b1000) begin fails++; $display("FAIL lb_bytes: got %b want 1000", by); end
      do_access(1'b0, 3'b100, 32'h13, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (rd !== 32'h000000AB) begin fails++; $display("FAIL lbu_rd: got %h want 000000ab", rd); end
      do_access(1'b0, 3'b000, 32'h11, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (rd !== 32'hFFFFFFBE) begin fails++; $display("FAIL lb_lane1_rd: got %h want ffffffbe", rd); end
   endtask

   task automatic test_half();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      do_access(1'b1, 3'b010, 32'h10, 32'h80011234, rd, err, st, rq, by, mwd, mad);
      do_access(1'b0, 3'b001, 32'h12, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (by !== 4'b1100) begin fails++; $display("FAIL lh_bytes: got %b want 1100", by); end
      checks++; if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_rd: got %h want ffff8001", rd); end
      do_access(1'b0, 3'b101, 32'h12, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_rd: got %h want 00008001", rd); end
      do_access(1'b0, 3'b001, 32'h10, 32'h0, rd, err, st, rq, by, mwd, mad);
      checks++; if (rd !== 32'h00001234) begin fails++; $display("FAIL lh_low_rd: got %h want 00001234", rd); end
      do_access(1'b1, 3'b001, 32'h22, 32'hFFFF5678, rd, err, st, rq, by, mwd, mad);
      checks++; if (mwd !== 32'h56785678 || by !== 4'b1100) begin
         fails++; $display("FAIL sh_bus: got wd=%h bytes=%b want 56785678/1100", mwd, by);
      end
   endtask

   task automatic test_illegal();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      logic [2:0]  sz [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
      logic [31:0] ad [4] = '{32'h2, 32'h0, 32'h11, 32'h4};
      logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         do_access(we[i], sz[i], ad[i], 32'h0, rd, err, st, rq, by, mwd, mad);
         checks++;
         if (rq !== 0 || st !== 1 || err !== 1'b1 || rd !== 32'd0) begin
            fails++;
            $display("FAIL illegal_%0d: got reqs=%0d stall=%0d err=%b rd=%h want 0/1/1/0", i, rq, st, err, rd);
         end
      end
      #1;
      checks++; if (ERR_OUT !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0 after DONE", ERR_OUT); end
   endtask

   task automatic test_timeout();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      gnt_en = 1'b0;
      do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, err, st, rq, by, mwd, mad);
      gnt_en = 1'b1;
      checks++; if (rq !== 16) begin fails++; $display("FAIL timeout_req_cycles: got %0d want 16", rq); end
      checks++; if (err !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL timeout_done: got err=%b rd=%h want 1/0", err, rd); end
      #1;
      checks++; if (MEM_REQ !== 1'b0) begin fails++; $display("FAIL timeout_req_after: got %b want 0", MEM_REQ); end
   endtask

   task automatic test_mem_err();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      err_inj = 1'b1;
      do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, err, st, rq, by, mwd, mad);
      err_inj = 1'b0;
      checks++; if (err !== 1'b1 || rd !== 32'd0 || st !== 3) begin
         fails++; $display("FAIL mem_err: got err=%b rd=%h stall=%0d want 1/0/3", err, rd, st);
      end
   endtask

   task automatic test_req_drop();
      @(negedge CLK);
      REQ_IN = 1'b1; WE_IN = 1'b0; SIZE = 3'b010; A = 32'h10; WD_IN = 32'h0;
      @(negedge CLK);
      REQ_IN = 1'b0;
      @(negedge CLK);
      @(negedge CLK); #1;
      checks++; if (RD_OUT !== 32'h80011234 || ERR_OUT !== 1'b0) begin
         fails++; $display("FAIL req_drop_done: got rd=%h err=%b want 80011234/0", RD_OUT, ERR_OUT);
      end
      @(negedge CLK); #1;
      checks++; if (RD_OUT !== 32'd0 || MEM_REQ !== 1'b0) begin
         fails++; $display("FAIL req_drop_idle: got rd=%h req=%b want 0/0", RD_OUT, MEM_REQ);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, mwd, mad; logic err; int st, rq; logic [3:0] by;
      @(negedge CLK);
      REQ_IN = 1'b1; WE_IN = 1'b0; SIZE = 3'b010; A = 32'h10; WD_IN = 32'h0;
      @(negedge CLK);
      @(negedge CLK); #1;
      checks++; if (MEM_REQ !== 1'b0 || STALL !== 1'b1) begin
         fails++; $display("FAIL wait_state: got req=%b stall=%b want 0/1", MEM_REQ, STALL);
      end
      RST = 1'b1; REQ_IN = 1'b0;
      @(negedge CLK); #1;
      checks++; if (STALL !== 1'b0 || ERR_OUT !== 1'b0 || MEM_REQ !== 1'b0 || RD_OUT !== 32'd0) begin
         fails++; $display("FAIL reset_mid: got stall=%b err=%b req=%b rd=%h want 0/0/0/0", STALL, ERR_OUT, MEM_REQ, RD_OUT);
      end
      RST = 1'b0;
      @(negedge CLK); #1;
      checks++; if (ERR_OUT !== 1'b0) begin fails++; $display("FAIL reset_mid_err: got %b want 0", ERR_OUT); end
      do_access(1'b1, 3'b010, 32'h20, 32'h12345678, rd, err, st, rq, by, mwd, mad);
      checks++; if (st !== 3 || err !== 1'b0 || mem[8] !== 32'h12345678) begin
         fails++; $display("FAIL post_reset_sw: got stall=%0d err=%b mem=%h want 3/0/12345678", st, err, mem[8]);
      end
   endtask

   initial begin
      RST = 1'b1; REQ_IN = 1'b0; WE_IN = 1'b0; SIZE = 3'b000; A = 32'd0; WD_IN = 32'd0;
      gnt_en = 1'b1; err_inj = 1'b0;
      repeat (2) @(negedge CLK);
      test_reset();
      test_sw();
      test_byte();
      test_half();
      test_illegal();
      test_timeout();
      test_req_drop();
      test_mem_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
